// File: rtl/udp_reg_ring_master_pkg.sv
// rtl/udp_reg_ring_master_pkg.sv - shared widths, dead-data pattern, FSM encodings for the ring master
`ifndef UDP_REG_ADDR_WIDTH
`define UDP_REG_ADDR_WIDTH 27
`endif
`ifndef CPCI_NF2_DATA_WIDTH
`define CPCI_NF2_DATA_WIDTH 32
`endif

package udp_reg_ring_master_pkg;
  localparam int ADDR_W  = `UDP_REG_ADDR_WIDTH;
  localparam int DATA_W  = `CPCI_NF2_DATA_WIDTH;
  localparam int TIMER_W = 16;

  localparam logic [DATA_W-1:0] REG_DEAD_DATA = 32'hdead_beef;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_ISSUE     = 3'd1;
  localparam logic [2:0] ST_WAIT_RESP = 3'd2;
  localparam logic [2:0] ST_ACK       = 3'd3;
  localparam logic [2:0] ST_DRAIN     = 3'd4;

  // Launch fields of the ring request; the tag is kept apart because its width is a parameter.
  typedef struct packed {
    logic              req;
    logic              rd_wr_L;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } ring_req_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hffff_ffff) ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/udp_reg_ring_master_if.sv
// rtl/udp_reg_ring_master_if.sv - host access port and ring launch/return bundle for the ring master
interface udp_reg_ring_master_if #(parameter int SRC_W = 2);
  import udp_reg_ring_master_pkg::*;

  logic              core_reg_req;
  logic              core_reg_rd_wr_L;
  logic [ADDR_W-1:0] core_reg_addr;
  logic [DATA_W-1:0] core_reg_wr_data;
  logic              core_reg_ack;
  logic [DATA_W-1:0] core_reg_rd_data;
  logic              core_reg_err;

  logic              reg_req_out;
  logic              reg_ack_out;
  logic              reg_rd_wr_L_out;
  logic [ADDR_W-1:0] reg_addr_out;
  logic [DATA_W-1:0] reg_data_out;
  logic [SRC_W-1:0]  reg_src_out;

  logic              reg_req_in;
  logic              reg_ack_in;
  logic              reg_rd_wr_L_in;
  logic [ADDR_W-1:0] reg_addr_in;
  logic [DATA_W-1:0] reg_data_in;
  logic [SRC_W-1:0]  reg_src_in;

  modport master (
    input  core_reg_req, core_reg_rd_wr_L, core_reg_addr, core_reg_wr_data,
    output core_reg_ack, core_reg_rd_data, core_reg_err,
    output reg_req_out, reg_ack_out, reg_rd_wr_L_out, reg_addr_out, reg_data_out, reg_src_out,
    input  reg_req_in, reg_ack_in, reg_rd_wr_L_in, reg_addr_in, reg_data_in, reg_src_in
  );

  modport slave (
    output core_reg_req, core_reg_rd_wr_L, core_reg_addr, core_reg_wr_data,
    input  core_reg_ack, core_reg_rd_data, core_reg_err,
    input  reg_req_out, reg_ack_out, reg_rd_wr_L_out, reg_addr_out, reg_data_out, reg_src_out,
    output reg_req_in, reg_ack_in, reg_rd_wr_L_in, reg_addr_in, reg_data_in, reg_src_in
  );
endinterface

// File: rtl/reg_master_timer.sv
// rtl/reg_master_timer.sv - response timeout down-counter; expired while the count sits at zero
module reg_master_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         expired_o
);
  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == '0);
endmodule

// File: rtl/udp_reg_ring_master.sv
// rtl/udp_reg_ring_master.sv - ring initiator: one host access in flight, terminates the ring, times out
// Optional UDP_REG_RING_MASTER_STATS_EN adds saturating timeout / stray-return counters.
module udp_reg_ring_master
  import udp_reg_ring_master_pkg::*;
#(
  parameter int UDP_REG_SRC_WIDTH = 2,
  parameter int SRC_ID            = 0,
  parameter int TIMEOUT           = 1023
) (
  input logic                   clk,
  input logic                   reset,
  udp_reg_ring_master_if.master bus
`ifdef UDP_REG_RING_MASTER_STATS_EN
  ,
  output logic [31:0]           num_timeouts,
  output logic [31:0]           num_stray_resp
`endif
);
  localparam logic [UDP_REG_SRC_WIDTH-1:0] SRC_TAG     = UDP_REG_SRC_WIDTH'(SRC_ID);
  localparam logic [TIMER_W-1:0]           TIMEOUT_VAL = TIMER_W'(TIMEOUT);

  logic [2:0]                   state_q, state_d;
  ring_req_t                    ring_q, ring_d;
  logic [UDP_REG_SRC_WIDTH-1:0] src_q, src_d;
  logic [DATA_W-1:0]            rd_data_q, rd_data_d;
  logic                         err_q, err_d;
  logic                         ack_q, ack_d;
  logic                         hit, timer_load, timer_dec, timer_expired;
  logic                         unused_ring_in;

  assign hit            = bus.reg_req_in && (bus.reg_src_in == SRC_TAG);
  assign unused_ring_in = ^{bus.reg_rd_wr_L_in, bus.reg_addr_in};

  reg_master_timer #(.W(TIMER_W)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (timer_load),
    .load_val_i (TIMEOUT_VAL),
    .dec_i      (timer_dec),
    .expired_o  (timer_expired)
  );

  always_comb begin
    state_d    = state_q;
    ring_d     = '0;
    src_d      = '0;
    rd_data_d  = rd_data_q;
    err_d      = err_q;
    ack_d      = 1'b0;
    timer_load = 1'b0;
    timer_dec  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Ring registers double as the request latch: loaded here, visible for the ISSUE cycle.
        if (bus.core_reg_req) begin
          ring_d.req     = 1'b1;
          ring_d.rd_wr_L = bus.core_reg_rd_wr_L;
          ring_d.addr    = bus.core_reg_addr;
          ring_d.data    = bus.core_reg_rd_wr_L ? '0 : bus.core_reg_wr_data;
          src_d          = SRC_TAG;
          state_d        = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        timer_load = 1'b1;
        state_d    = ST_WAIT_RESP;
      end
      ST_WAIT_RESP: begin
        if (hit) begin
          rd_data_d = bus.reg_ack_in ? bus.reg_data_in : REG_DEAD_DATA;
          err_d     = !bus.reg_ack_in;
          ack_d     = 1'b1;
          state_d   = ST_ACK;
        end else if (timer_expired) begin
          rd_data_d = REG_DEAD_DATA;
          err_d     = 1'b1;
          ack_d     = 1'b1;
          state_d   = ST_ACK;
        end else begin
          timer_dec = 1'b1;
        end
      end
      ST_ACK: begin
        state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!bus.core_reg_req) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      ring_q    <= '0;
      src_q     <= '0;
      rd_data_q <= '0;
      err_q     <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ring_q    <= ring_d;
      src_q     <= src_d;
      rd_data_q <= rd_data_d;
      err_q     <= err_d;
      ack_q     <= ack_d;
    end
  end

  assign bus.reg_req_out      = ring_q.req;
  assign bus.reg_ack_out      = 1'b0;
  assign bus.reg_rd_wr_L_out  = ring_q.rd_wr_L;
  assign bus.reg_addr_out     = ring_q.addr;
  assign bus.reg_data_out     = ring_q.data;
  assign bus.reg_src_out      = src_q;
  assign bus.core_reg_ack     = ack_q;
  assign bus.core_reg_err     = ack_q & err_q;
  assign bus.core_reg_rd_data = rd_data_q;

`ifdef UDP_REG_RING_MASTER_STATS_EN
  logic timeout_evt, stray_evt;
  logic [31:0] num_timeouts_q, num_stray_resp_q;

  assign timeout_evt = (state_q == ST_WAIT_RESP) && !hit && timer_expired;
  assign stray_evt   = bus.reg_req_in && !((state_q == ST_WAIT_RESP) && hit);

  always_ff @(posedge clk) begin
    if (reset) begin
      num_timeouts_q   <= '0;
      num_stray_resp_q <= '0;
    end else begin
      if (timeout_evt) num_timeouts_q <= sat_inc(num_timeouts_q);
      if (stray_evt) num_stray_resp_q <= sat_inc(num_stray_resp_q);
    end
  end

  assign num_timeouts   = num_timeouts_q;
  assign num_stray_resp = num_stray_resp_q;
`endif
endmodule
